// File: rtl/wish_pkg.sv
// Shared definitions for the wish_pack / wish_unpack streaming adapters:
// beat-index helpers and the two-state buffer encoding.
package wish_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_BUSY  = 1'b1;

  function automatic int unsigned idx_width(int unsigned num_pack);
    return (num_pack > 1) ? $clog2(num_pack) : 1;
  endfunction

  // Little endian walks 0 -> N-1, big endian walks N-1 -> 0.
  function automatic int unsigned start_idx(bit little_endian, int unsigned num_pack);
    return little_endian ? 0 : num_pack - 1;
  endfunction

  function automatic int unsigned last_idx(bit little_endian, int unsigned num_pack);
    return little_endian ? num_pack - 1 : 0;
  endfunction

endpackage

// File: rtl/wish_unpack.sv
// Splits one wide Wishbone-style word into NUM_PACK narrow beats in the configured
// endian order. Single word buffer, fully registered outputs, one bubble between words.
module wish_unpack
  import wish_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_PACK      = 4,
  parameter int unsigned TGC_WIDTH     = 2,
  parameter int unsigned LITTLE_ENDIAN = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  localparam int unsigned WW = DATA_WIDTH * NUM_PACK;
  localparam int unsigned IW = idx_width(NUM_PACK);
  localparam logic [IW-1:0] IDX_START = IW'(start_idx(LITTLE_ENDIAN != 0, NUM_PACK));
  localparam logic [IW-1:0] IDX_LAST  = IW'(last_idx(LITTLE_ENDIAN != 0, NUM_PACK));

  logic                  state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WW-1:0]         buf_q, buf_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [TGC_WIDTH-1:0]  tgc_q, tgc_d;
  logic                  ack_q, ack_d;
  logic                  stall_q, stall_d;
  logic                  accept;

  assign accept = (state_q == ST_EMPTY) && s_stb_i && s_cyc_i && !stall_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    dat_d   = dat_q;
    tgc_d   = tgc_q;
    ack_d   = 1'b0;
    if (accept) begin
      buf_d   = s_dat_i;
      tgc_d   = s_tgc_i;
      dat_d   = s_dat_i[int'(IDX_START) * DATA_WIDTH +: DATA_WIDTH];
      idx_d   = IDX_START;
      state_d = ST_BUSY;
      ack_d   = 1'b1;
    end else if ((state_q == ST_BUSY) && d_ack_i) begin
      if (idx_q == IDX_LAST) begin
        state_d = ST_EMPTY;
        idx_d   = IDX_START;
      end else begin
        idx_d = (LITTLE_ENDIAN != 0) ? idx_q + IW'(1) : idx_q - IW'(1);
        dat_d = buf_q[int'(idx_d) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // Stall stays low in the ack cycle so ack and stall never overlap.
    stall_d = (state_d == ST_BUSY) && !accept;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      idx_q   <= IDX_START;
      buf_q   <= '0;
      dat_q   <= '0;
      tgc_q   <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      dat_q   <= dat_d;
      tgc_q   <= tgc_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
    end
  end

  assign s_ack_o   = ack_q;
  assign s_stall_o = stall_q;
  assign d_stb_o   = (state_q == ST_BUSY);
  assign d_cyc_o   = (state_q == ST_BUSY);
  assign d_dat_o   = dat_q;
  assign d_tgc_o   = tgc_q;

endmodule
